// File: rtl/sm_imem_loader_pkg.sv
// Shared types and helpers for the sm_cpu instruction memory and its program loader.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package sm_imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        LDR_BOOT = 2'd0,
        LDR_RUN  = 2'd1,
        LDR_LOAD = 2'd2,
        LDR_DONE = 2'd3
    } ldrState_t;

    // MIPS nop, fed to the core whenever the memory is not being served
    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

    // Place a byte into the selected little-endian lane of a word
    function automatic logic [31:0] laneInsert(input logic [31:0] word,
                                               input logic [7:0]  b,
                                               input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sm_imem_ram.sv
// Instruction word array: one synchronous write port, one asynchronous read port.
// Latency: read combinational; write lands on the clock edge.
// Backpressure: none; a same-cycle read of the written word returns the old contents.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset on the array.
module sm_imem_ram #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sm_imem_loader.sv
// Instruction memory for sm_cpu with a byte-stream program loader that holds the core in reset.
// Latency: imData combinational from imAddr; each accepted byte is absorbed in the same edge.
// Backpressure: ld_ready high only while loading; bytes offered outside a load are not taken.
// Ports: clk/rst_n; imAddr/imData (core fetch); cpu_rst_n (core reset);
//        ld_start, ld_valid/ld_ready/ld_data/ld_last (byte stream); ld_done, ld_overflow, ld_count (status).
module sm_imem_loader
    import sm_imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           imAddr,
    output logic [31:0]           imData,
    output logic                  cpu_rst_n,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_done,
    output logic                  ld_overflow,
    output logic [ADDR_WIDTH:0]   ld_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ldrState_t             state;
    logic [1:0]            bcnt;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           asmWord;     // bytes of the word in progress; unfilled lanes stay 0

    logic                  hs;
    logic                  wordEnd;
    logic                  memWe;
    logic [31:0]           wordNext;
    logic [31:0]           ramRdata;
    logic                  unusedAddrBits;

    assign hs       = ld_valid & ld_ready;
    assign wordNext = laneInsert(asmWord, ld_data, bcnt);
    assign wordEnd  = (bcnt == 2'd3) | ld_last;
    assign memWe    = hs & wordEnd;

    sm_imem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (memWe),
        .waddr (waddr),
        .wdata (wordNext),
        .raddr (imAddr[ADDR_WIDTH-1:0]),
        .rdata (ramRdata)
    );

    // Upper pc bits are dropped, so fetches alias modulo the depth
    assign unusedAddrBits = |imAddr[31:ADDR_WIDTH];

    // The core only ever sees real instructions while it is out of reset
    assign imData = (state == LDR_RUN) ? ramRdata : IMEM_NOP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LDR_BOOT;
            cpu_rst_n   <= 1'b0;
            ld_ready    <= 1'b0;
            ld_done     <= 1'b0;
            ld_overflow <= 1'b0;
            ld_count    <= '0;
            bcnt        <= '0;
            waddr       <= '0;
            asmWord     <= '0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                LDR_BOOT: begin
                    state     <= LDR_RUN;
                    cpu_rst_n <= 1'b1;
                end

                LDR_RUN: begin
                    if (ld_start) begin
                        state       <= LDR_LOAD;
                        cpu_rst_n   <= 1'b0;
                        ld_ready    <= 1'b1;
                        ld_overflow <= 1'b0;
                        ld_count    <= '0;
                        bcnt        <= '0;
                        waddr       <= '0;
                        asmWord     <= '0;
                    end
                end

                LDR_LOAD: begin
                    if (hs) begin
                        if (wordEnd) begin
                            // word already written via memWe this edge; start a fresh one
                            asmWord  <= '0;
                            bcnt     <= '0;
                            waddr    <= waddr + 1'b1;
                            ld_count <= ld_count + 1'b1;
                            if (ld_last) begin
                                state    <= LDR_DONE;
                                ld_ready <= 1'b0;
                                ld_done  <= 1'b1;
                            end else if (waddr == LAST_ADDR) begin
                                // memory full but image still going: stop and flag it
                                state       <= LDR_DONE;
                                ld_ready    <= 1'b0;
                                ld_done     <= 1'b1;
                                ld_overflow <= 1'b1;
                            end
                        end else begin
                            asmWord <= wordNext;
                            bcnt    <= bcnt + 2'd1;
                        end
                    end
                end

                default: begin  // LDR_DONE
                    state     <= LDR_RUN;
                    cpu_rst_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_imem_loader.sv
module tb_sm_imem_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic [31:0]   imAddr;
    logic [31:0]   imData;
    logic          cpu_rst_n;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_done;
    logic          ld_overflow;
    logic [AW:0]   ld_count;

    int checks = 0;
    int errors = 0;

    // reference memory: what each word should hold, and whether it is defined yet
    logic [31:0] model [DEPTH];
    bit          known [DEPTH];
    logic [7:0]  img [$];

    sm_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imAddr      (imAddr),
        .imData      (imData),
        .cpu_rst_n   (cpu_rst_n),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_done     (ld_done),
        .ld_overflow (ld_overflow),
        .ld_count    (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Image bytes packed little-endian into consecutive words, partial last word zero-filled
    task automatic applyImage(input int acc);
        for (int w = 0; w < (acc + 3) / 4; w++) begin
            logic [31:0] word;
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < acc) word = word | (32'(img[4 * w + k]) << (8 * k));
            end
            model[w] = word;
            known[w] = 1'b1;
        end
    endtask

    task automatic readBack(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            if (known[a]) begin
                imAddr = 32'(a) + (32'($urandom_range(0, 1000)) << AW);
                #1;
                checkVal(tag, imData, model[a]);
            end
        end
        imAddr = 32'h0;
    endtask

    task automatic startLoad();
        @(negedge clk);
        // bytes offered in the start cycle must be ignored
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b1;
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        checkVal("cpuRstInLoad", cpu_rst_n, 1'b0);
        checkVal("readyInLoad", ld_ready, 1'b1);
        imAddr = 32'h0;
        #1;
        checkVal("imDataForced", imData, 32'h0);
    endtask

    task automatic runLoad(input bit withLast, input bit gaps, input bit pulses);
        int idx;
        int cyc;
        int acc;
        idx = 0;
        cyc = 0;
        startLoad();
        while (ld_ready && cyc < 3000) begin
            ld_start = pulses && ($urandom_range(0, 3) == 0);
            if (idx < img.size() && !(gaps && $urandom_range(0, 2) == 0)) begin
                ld_valid = 1'b1;
                ld_data  = img[idx];
                ld_last  = withLast && (idx == img.size() - 1);
            end else begin
                ld_valid = 1'b0;
                ld_last  = 1'b0;
            end
            @(posedge clk);
            if (ld_valid) idx++;
            @(negedge clk);
            cyc++;
        end
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
        acc = withLast ? img.size() : DEPTH * 4;
        checkVal("loadEnded", ld_ready, 1'b0);
        checkVal("bytesTaken", idx, acc);
        checkVal("ldDonePulse", ld_done, 1'b1);
        checkVal("cpuRstAtDone", cpu_rst_n, 1'b0);
        checkVal("ldCount", ld_count, (acc + 3) / 4);
        checkVal("ldOverflow", ld_overflow, !withLast);
        @(negedge clk);
        checkVal("ldDoneOnce", ld_done, 1'b0);
        checkVal("cpuRstAfter", cpu_rst_n, 1'b1);
        applyImage(acc);
        readBack("readBack");
    endtask

    task automatic randomImage(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; imAddr = 32'h0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_data = 8'h0; ld_last = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        checkVal("rstCpuRst", cpu_rst_n, 1'b0);
        checkVal("rstReady", ld_ready, 1'b0);
        checkVal("rstDone", ld_done, 1'b0);
        checkVal("rstOverflow", ld_overflow, 1'b0);
        checkVal("rstCount", ld_count, 0);
        checkVal("rstImData", imData, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkVal("bootToRun", cpu_rst_n, 1'b1);

        // two-word image
        img = '{8'h05, 8'h00, 8'h08, 8'h24, 8'h01, 8'h00, 8'h09, 8'h25};
        runLoad(1'b1, 1'b0, 1'b0);
        imAddr = 32'h0; #1;
        checkVal("word0", imData, 32'h2408_0005);
        imAddr = 32'h1; #1;
        checkVal("word1", imData, 32'h2509_0001);

        // partial last word
        img = '{8'hAA, 8'hBB, 8'hCC};
        runLoad(1'b1, 1'b0, 1'b0);
        imAddr = 32'h0; #1;
        checkVal("partialWord", imData, 32'h00CC_BBAA);

        // random images with valid gaps and stray ld_start pulses
        for (int r = 0; r < 4; r++) begin
            randomImage($urandom_range(1, 60));
            runLoad(1'b1, 1'b1, 1'b1);
        end
        randomImage(24);
        runLoad(1'b1, 1'b1, 1'b1);
        imAddr = 32'h44; #1;
        checkVal("aliasRead", imData, model[4]);

        // image larger than the memory, no ld_last
        randomImage(DEPTH * 4 + 1);
        runLoad(1'b0, 1'b0, 1'b0);

        // overflow flag clears on the next load
        randomImage(5);
        runLoad(1'b1, 1'b0, 1'b0);

        // reset in the middle of a load
        randomImage(8);
        startLoad();
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1; ld_data = img[i]; ld_last = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkVal("midRstCpuRst", cpu_rst_n, 1'b0);
        checkVal("midRstReady", ld_ready, 1'b0);
        checkVal("midRstImData", imData, 32'h0);
        checkVal("midRstCount", ld_count, 0);
        applyImage(4);   // only the completed first word survives
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkVal("midRstRun", cpu_rst_n, 1'b1);
        readBack("afterRst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
